mips150_mem_align: RTL and testbench

//  Data-memory access stage downstream of the MIPS150 control decoder. Consumes Mask/MemWrite,

---
 rtl/mips150_mem_align_pkg.sv | 80 ++++++++
 rtl/mips150_mem_align_load_extract.sv | 52 +++++
 rtl/mips150_mem_align.sv | 154 +++++++++++++++
 tb/tb_mips150_mem_align.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips150_mem_align_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips150_mem_align_pkg
// Purpose : Shared encodings for the MIPS150 data-memory access stage.
//           It holds the load mask codes, the store kind codes and the FSM
//           state encodings. It also holds helpers that derive alignment,
//           byte-lane enables and replicated store data.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mips150_mem_align_pkg;

  // Load kinds carried on the mask bus
  localparam logic [2:0] MASK_LB  = 3'b000;
  localparam logic [2:0] MASK_LH  = 3'b001;
  localparam logic [2:0] MASK_LW  = 3'b010;
  localparam logic [2:0] MASK_LBU = 3'b011;
  localparam logic [2:0] MASK_LHU = 3'b100;

  // Store kinds carried on the mem_write bus
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SB   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SW   = 2'b11;

  // FSM encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Halfword stores need an even address; word stores need a word address.
  function automatic logic store_misaligned(input logic [1:0] mw, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (mw)
      MW_SH:   mis = off[0];
      MW_SW:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Unused mask codes act like byte loads for alignment; they simply return 0.
  function automatic logic load_misaligned(input logic [2:0] m, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (m)
      MASK_LH, MASK_LHU: mis = off[0];
      MASK_LW:           mis = (off != 2'b00);
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Big-endian lane enables: bit3 is lane 0 (bits [31:24]).
  function automatic logic [3:0] store_we(input logic [1:0] mw, input logic [1:0] off);
    logic [3:0] we;
    we = 4'b0000;
    case (mw)
      MW_SB:   we = 4'b1000 >> off;
      MW_SH:   we = off[1] ? 4'b0011 : 4'b1100;
      MW_SW:   we = 4'b1111;
      default: we = 4'b0000;
    endcase
    return we;
  endfunction

  // The source value is copied into every lane so the enables alone pick the target.
  function automatic logic [31:0] store_wdata(input logic [1:0] mw, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    case (mw)
      MW_SB:   w = {4{d[7:0]}};
      MW_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips150_mem_align_load_extract.sv
`default_nettype none
// ============================================================================
// Module  : mips150_load_extract
// Purpose : Combinational load lane select and extension.
//           Lane k of the read word is rdata[31-8k -: 8] (big-endian).
//           LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
//           Unused mask codes return zero.
// Ports   : rdata_i [31:0]  read word from memory
//           mask_i  [2:0]   load kind captured at request time
//           off_i   [1:0]   byte offset captured at request time
//           data_o  [31:0]  aligned, extended result
// Revision: 1.0 - initial release
// ============================================================================
module mips150_load_extract
  import mips150_mem_align_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  mask_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (off_i)
      2'd0:    w_byte = rdata_i[31:24];
      2'd1:    w_byte = rdata_i[23:16];
      2'd2:    w_byte = rdata_i[15:8];
      default: w_byte = rdata_i[7:0];
    endcase
  end

  // Halfword loads are even-aligned, so only off_i[1] selects the half.
  assign w_half = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];

  always_comb begin
    data_o = 32'h0000_0000;
    case (mask_i)
      MASK_LB:  data_o = {{24{w_byte[7]}}, w_byte};
      MASK_LH:  data_o = {{16{w_half[15]}}, w_half};
      MASK_LW:  data_o = rdata_i;
      MASK_LBU: data_o = {24'h000000, w_byte};
      MASK_LHU: data_o = {16'h0000, w_half};
      default:  data_o = 32'h0000_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips150_mem_align.sv
`default_nettype none
// ============================================================================
// Module  : mips150_mem_align
// Purpose : Data-memory access stage. It turns stores into byte-lane write
//           enables with replicated data and issues loads. It waits for read
//           data, with a timeout, then returns the aligned and extended word.
//           The pipeline is stalled while a load is outstanding.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           stall_in                 blocks acceptance of new requests
//           mem_read, mask[2:0]      load request and load kind
//           mem_write[1:0]           store kind (has priority over loads)
//           addr[31:0], store_data   effective address, store source
//           dmem_en/we/addr/wdata    memory request (combinational)
//           dmem_rdata, dmem_rvalid  memory response
//           load_data, load_valid    load result and one-cycle valid (reg.)
//           stall_out                high while in WAIT
//           misalign, bus_err        one-cycle error pulses (reg.)
// Revision: 1.0 - initial release
// ============================================================================
module mips150_mem_align
  import mips150_mem_align_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        mem_read,
  input  logic [2:0]  mask,
  input  logic [1:0]  mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_en,
  output logic [3:0]  dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall_out,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       ctx_mask_q;
  logic [1:0]       ctx_off_q;
  logic [31:0]      load_data_q;
  logic             load_valid_q;
  logic             misalign_q;
  logic             bus_err_q;

  logic             w_accept;
  logic             w_is_store;
  logic             w_is_load;
  logic             w_store_mis;
  logic             w_load_mis;
  logic             w_store_go;
  logic             w_load_go;
  logic             w_mis;
  logic             w_done;
  logic             w_tout;
  logic [31:0]      w_extract;

  // Request decode. rst gates acceptance so no strobe leaks out during reset.
  assign w_accept    = (state_q == ST_IDLE) && !stall_in && !rst;
  assign w_is_store  = (mem_write != MW_NONE);
  assign w_is_load   = mem_read && !w_is_store;   // a store drops a coincident load
  assign w_store_mis = store_misaligned(mem_write, addr[1:0]);
  assign w_load_mis  = load_misaligned(mask, addr[1:0]);
  assign w_store_go  = w_accept && w_is_store && !w_store_mis;
  assign w_load_go   = w_accept && w_is_load && !w_load_mis;
  assign w_mis       = w_accept && ((w_is_store && w_store_mis) || (w_is_load && w_load_mis));

  // Completion: rvalid beats a timeout that lands on the same cycle.
  assign w_done = (state_q == ST_WAIT) && dmem_rvalid;
  assign w_tout = (state_q == ST_WAIT) && !dmem_rvalid && (cnt_q == C_CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_load_go)          state_d = ST_WAIT;
      ST_WAIT: if (w_done || w_tout)   state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    dmem_en    = w_store_go || w_load_go;
    dmem_we    = w_store_go ? store_we(mem_write, addr[1:0]) : 4'b0000;
    dmem_addr  = addr[31:2];
    dmem_wdata = store_wdata(mem_write, store_data);
    stall_out  = (state_q == ST_WAIT);
  end

  // Load context, timeout counter and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      ctx_mask_q   <= MASK_LB;
      ctx_off_q    <= 2'b00;
      load_data_q  <= 32'h0000_0000;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      load_valid_q <= w_done;
      bus_err_q    <= w_tout;
      misalign_q   <= w_mis;
      if (w_load_go) begin
        ctx_mask_q <= mask;
        ctx_off_q  <= addr[1:0];
        cnt_q      <= '0;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (w_done) begin
        load_data_q <= w_extract;
      end else if (w_tout) begin
        load_data_q <= 32'h0000_0000;
      end
    end
  end

  mips150_load_extract u_extract (
    .rdata_i (dmem_rdata),
    .mask_i  (ctx_mask_q),
    .off_i   (ctx_off_q),
    .data_o  (w_extract)
  );

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mips150_mem_align.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips150_mem_align
// Purpose : Self-checking bench for mips150_mem_align using randomized and
//           directed stimulus against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips150_mem_align;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        mem_read;
  logic [2:0]  mask;
  logic [1:0]  mem_write;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall_out;
  logic        misalign;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mips150_mem_align #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_in    (stall_in),
    .mem_read    (mem_read),
    .mask        (mask),
    .mem_write   (mem_write),
    .addr        (addr),
    .store_data  (store_data),
    .dmem_en     (dmem_en),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_rvalid (dmem_rvalid),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .stall_out   (stall_out),
    .misalign    (misalign),
    .bus_err     (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int access_size_load(input logic [2:0] m);
    if (m == 3'd1 || m == 3'd4) return 2;
    if (m == 3'd2) return 4;
    return 1;
  endfunction

  function automatic int access_size_store(input logic [1:0] mw);
    if (mw == 2'd1) return 1;
    if (mw == 2'd2) return 2;
    return 4;
  endfunction

  // Enable for every byte the access touches; byte k lives on we bit 3-k.
  function automatic logic [3:0] ref_we(input logic [1:0] mw, input logic [31:0] a);
    logic [3:0] we;
    int sz;
    int base;
    we = 4'b0000;
    sz = access_size_store(mw);
    base = int'(a % 4);
    for (int k = base; k < base + sz; k++) we[3-k] = 1'b1;
    return we;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] mw, input logic [31:0] d);
    if (mw == 2'd1) return (d & 32'hFF) * 32'h0101_0101;
    if (mw == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_extract(input logic [2:0] m, input logic [31:0] a,
                                              input logic [31:0] rd);
    int off;
    logic [31:0] b;
    logic [31:0] h;
    off = int'(a % 4);
    b = (rd >> (8 * (3 - off))) & 32'hFF;
    h = (rd >> (8 * (2 - (off & 2)))) & 32'hFFFF;
    case (m)
      3'd0:    return (b ^ 32'h80) - 32'h80;
      3'd1:    return (h ^ 32'h8000) - 32'h8000;
      3'd2:    return rd;
      3'd3:    return b;
      3'd4:    return h;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    stall_in    = 1'b0;
    mem_read    = 1'b0;
    mask        = 3'd0;
    mem_write   = 2'd0;
    addr        = 32'h0;
    store_data  = 32'h0;
    dmem_rdata  = 32'h0;
    dmem_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    idle_in();
    mem_write = 2'd3;
    mem_read  = 1'b1;
    addr      = $urandom & 32'hFFFF_FFFC;
    tick();
    tick();
    #1;
    checks++;
    if (dmem_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", dmem_en); end
    checks++;
    if (dmem_we !== 4'b0000) begin errors++; $display("FAIL rst_we got %b want 0000", dmem_we); end
    checks++;
    if ({load_data, load_valid, misalign, bus_err, stall_out} !== 36'h0) begin
      errors++;
      $display("FAIL rst_regs got ld=%h lv=%b mis=%b be=%b st=%b want all 0",
               load_data, load_valid, misalign, bus_err, stall_out);
    end
    tick();
    rst = 1'b0;
    idle_in();
  endtask

  task automatic test_store_directed;
    tick();
    mem_write = 2'd1; addr = 32'h1002; store_data = 32'h0000_00A5;
    #1;
    checks++;
    if ({dmem_en, dmem_we} !== 5'b1_0010) begin
      errors++; $display("FAIL sb_we got en=%b we=%b want en=1 we=0010", dmem_en, dmem_we);
    end
    checks++;
    if (dmem_wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", dmem_wdata);
    end
    checks++;
    if (dmem_addr !== 30'h400) begin
      errors++; $display("FAIL sb_addr got %h want 400", dmem_addr);
    end
    tick();
    idle_in();
    #1;
    checks++;
    if ({misalign, stall_out} !== 2'b00) begin
      errors++; $display("FAIL sb_after got mis=%b st=%b want 0 0", misalign, stall_out);
    end
    // Misaligned halfword store
    mem_write = 2'd2; addr = 32'h3; store_data = 32'h1234;
    #1;
    checks++;
    if ({dmem_en, dmem_we} !== 5'b0) begin
      errors++; $display("FAIL sh_mis_en got en=%b we=%b want 0", dmem_en, dmem_we);
    end
    tick();
    idle_in();
    #1;
    checks++;
    if ({misalign, stall_out} !== 2'b10) begin
      errors++; $display("FAIL sh_mis_pulse got mis=%b st=%b want 1 0", misalign, stall_out);
    end
    tick();
    checks++;
    if (misalign !== 1'b0) begin
      errors++; $display("FAIL sh_mis_width got %b want 0", misalign);
    end
  endtask

  task automatic test_store_random;
    logic [1:0]  mw;
    logic [31:0] a;
    logic [31:0] d;
    logic        mis;
    for (int i = 0; i < 40; i++) begin
      tick();
      mw = 2'($urandom_range(1, 3));
      a = $urandom;
      d = $urandom;
      mis = (a % access_size_store(mw)) != 0;
      mem_write = mw; addr = a; store_data = d;
      mem_read = 1'($urandom_range(0, 1));
      mask = 3'($urandom_range(0, 4));
      #1;
      checks++;
      if (dmem_en !== !mis) begin
        errors++; $display("FAIL st_en[%0d] got %b want %b", i, dmem_en, !mis);
      end
      checks++;
      if (dmem_we !== (mis ? 4'b0000 : ref_we(mw, a))) begin
        errors++; $display("FAIL st_we[%0d] got %b want %b", i, dmem_we,
                           mis ? 4'b0000 : ref_we(mw, a));
      end
      checks++;
      if (dmem_wdata !== ref_wdata(mw, d)) begin
        errors++; $display("FAIL st_wdata[%0d] got %h want %h", i, dmem_wdata, ref_wdata(mw, d));
      end
      checks++;
      if (dmem_addr !== a[31:2]) begin
        errors++; $display("FAIL st_addr[%0d] got %h want %h", i, dmem_addr, a[31:2]);
      end
      tick();
      idle_in();
      #1;
      checks++;
      if ({misalign, stall_out} !== {mis, 1'b0}) begin
        errors++; $display("FAIL st_post[%0d] got mis=%b st=%b want %b 0", i, misalign, stall_out, mis);
      end
    end
  endtask

  task automatic test_load_random;
    logic [2:0]  m;
    logic [31:0] a;
    logic [31:0] rd;
    int          dly;
    int          stall_hi;
    logic        mis;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) begin m = 3'd4; a = 32'h2; rd = 32'hAAAA_8001; dly = 4; end
      else if (i == 1) begin m = 3'd0; a = 32'h1; rd = 32'h11F0_2233; dly = 0; end
      else if (i == 2) begin m = 3'd3; a = 32'h1; rd = 32'h11F0_2233; dly = 0; end
      else if (i == 3) begin m = 3'd2; a = $urandom & 32'hFFFF_FFFC; rd = $urandom; dly = TIMEOUT - 1; end
      else begin
        m = 3'($urandom_range(0, 7)); a = $urandom; rd = $urandom; dly = $urandom_range(0, 5);
      end
      mis = (a % access_size_load(m)) != 0;
      tick();
      mem_read = 1'b1; mask = m; addr = a;
      dmem_rvalid = 1'($urandom_range(0, 1));   // must be ignored in IDLE
      dmem_rdata = $urandom;
      #1;
      checks++;
      if ({dmem_en, dmem_we} !== {!mis, 4'b0000}) begin
        errors++; $display("FAIL ld_req[%0d] got en=%b we=%b want en=%b we=0000", i, dmem_en, dmem_we, !mis);
      end
      tick();
      idle_in();
      if (mis) begin
        #1;
        checks++;
        if ({misalign, stall_out, load_valid} !== 3'b100) begin
          errors++; $display("FAIL ld_mis[%0d] got mis=%b st=%b lv=%b want 1 0 0", i, misalign, stall_out, load_valid);
        end
      end else begin
        stall_hi = 0;
        for (int j = 0; j < dly; j++) begin
          stall_in = 1'($urandom_range(0, 1));
          dmem_rdata = $urandom;
          #1;
          if (stall_out) stall_hi++;
          checks++;
          if (load_valid !== 1'b0 || bus_err !== 1'b0) begin
            errors++; $display("FAIL ld_wait[%0d] got lv=%b be=%b want 0 0", i, load_valid, bus_err);
          end
          tick();
        end
        stall_in = 1'($urandom_range(0, 1));
        dmem_rvalid = 1'b1;
        dmem_rdata = rd;
        #1;
        if (stall_out) stall_hi++;
        tick();
        idle_in();
        #1;
        checks++;
        if (stall_hi !== dly + 1) begin
          errors++; $display("FAIL ld_stall[%0d] got %0d cycles want %0d", i, stall_hi, dly + 1);
        end
        checks++;
        if ({load_valid, stall_out, bus_err} !== 3'b100) begin
          errors++; $display("FAIL ld_done[%0d] got lv=%b st=%b be=%b want 1 0 0", i, load_valid, stall_out, bus_err);
        end
        checks++;
        if (load_data !== ref_extract(m, a, rd)) begin
          errors++; $display("FAIL ld_data[%0d] m=%0d a=%h got %h want %h", i, m, a, load_data, ref_extract(m, a, rd));
        end
        tick();
        checks++;
        if (load_valid !== 1'b0) begin
          errors++; $display("FAIL ld_pulse[%0d] got %b want 0", i, load_valid);
        end
      end
    end
  endtask

  task automatic test_timeout;
    int seen;
    seen = 0;
    tick();
    mem_read = 1'b1; mask = 3'd2; addr = $urandom & 32'hFFFF_FFFC;
    #1;
    checks++;
    if (dmem_en !== 1'b1) begin errors++; $display("FAIL to_req got %b want 1", dmem_en); end
    tick();
    idle_in();
    for (int c = 1; c <= 40; c++) begin
      if (bus_err) begin seen = c; break; end
      tick();
    end
    checks++;
    if (seen !== TIMEOUT + 1) begin
      errors++; $display("FAIL to_cycle got %0d want %0d", seen, TIMEOUT + 1);
    end
    checks++;
    if ({load_valid, stall_out, load_data} !== 34'h0) begin
      errors++; $display("FAIL to_state got lv=%b st=%b ld=%h want 0 0 0", load_valid, stall_out, load_data);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata = $urandom;
    tick();
    idle_in();
    #1;
    checks++;
    if ({load_valid, stall_out, bus_err} !== 3'b000) begin
      errors++; $display("FAIL to_late got lv=%b st=%b be=%b want 0 0 0", load_valid, stall_out, bus_err);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd2;
    rd2 = $urandom;
    tick();
    mem_read = 1'b1; mask = 3'd2; addr = 32'h100;
    tick();
    idle_in();
    tick();
    rst = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata = $urandom;
    #1;
    checks++;
    if ({dmem_en, dmem_we} !== 5'b0) begin
      errors++; $display("FAIL rw_rst_en got en=%b we=%b want 0", dmem_en, dmem_we);
    end
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1;             // late response, must be ignored
    dmem_rdata = $urandom;
    mem_read = 1'b1; mask = 3'd1; addr = 32'h200;
    #1;
    checks++;
    if ({load_valid, bus_err, misalign, stall_out, load_data} !== 36'h0) begin
      errors++; $display("FAIL rw_after got lv=%b be=%b mis=%b st=%b ld=%h want 0",
                         load_valid, bus_err, misalign, stall_out, load_data);
    end
    checks++;
    if (dmem_en !== 1'b1) begin errors++; $display("FAIL rw_new_en got %b want 1", dmem_en); end
    tick();
    idle_in();
    dmem_rvalid = 1'b1;
    dmem_rdata = rd2;
    #1;
    checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL rw_new_stall got %b want 1", stall_out); end
    tick();
    idle_in();
    #1;
    checks++;
    if ({load_valid, load_data} !== {1'b1, ref_extract(3'd1, 32'h200, rd2)}) begin
      errors++; $display("FAIL rw_new_done got lv=%b ld=%h want 1 %h", load_valid, load_data,
                         ref_extract(3'd1, 32'h200, rd2));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    test_reset();
    test_store_directed();
    test_store_random();
    test_load_random();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
